// File: rtl/axi_riscv_resv_table_pkg.sv
// axi_riscv_resv_pkg: shared constants and the saturating granule range compare
// used by every reservation slot.
package axi_riscv_resv_pkg;
    localparam int GRANULE_CNT_WIDTH = 8;
    localparam int MAX_GRANULE_WIDTH = 64;

    // One extra bit on the end granule means s + n can never wrap to zero.
    function automatic logic granule_in_range(
        input logic [MAX_GRANULE_WIDTH-1:0] g,
        input logic [MAX_GRANULE_WIDTH-1:0] s,
        input logic [GRANULE_CNT_WIDTH-1:0] n
    );
        logic [MAX_GRANULE_WIDTH:0] w_end;
        w_end = {1'b0, s} + (MAX_GRANULE_WIDTH+1)'(n);
        return (g >= s) && ({1'b0, g} <= w_end);
    endfunction
endpackage

// File: rtl/axi_riscv_resv_table_if.sv
// axi_riscv_resv_table_if: LR, SC, SC-response and write-snoop streams of the
// reservation table.
interface axi_riscv_resv_table_if
    import axi_riscv_resv_pkg::*;
#(
    parameter int ID_WIDTH    = 4,
    parameter int ADDR_WIDTH  = 64,
    parameter int NUM_ENTRIES = 4
);
    logic                                 lr_valid_i, lr_ready_o;
    logic [ID_WIDTH-1:0]                  lr_id_i;
    logic [ADDR_WIDTH-1:0]                lr_addr_i;
    logic                                 sc_valid_i, sc_ready_o;
    logic [ID_WIDTH-1:0]                  sc_id_i;
    logic [ADDR_WIDTH-1:0]                sc_addr_i;
    logic                                 sc_rsp_valid_o, sc_rsp_ready_i, sc_rsp_ok_o;
    logic [ID_WIDTH-1:0]                  sc_rsp_id_o;
    logic                                 wr_valid_i;
    logic [ADDR_WIDTH-1:0]                wr_addr_i;
    logic [GRANULE_CNT_WIDTH-1:0]         wr_granules_i;
    logic [$clog2(NUM_ENTRIES+1)-1:0]     resv_count_o;

    modport master (
        output lr_valid_i, lr_id_i, lr_addr_i, sc_valid_i, sc_id_i, sc_addr_i,
               sc_rsp_ready_i, wr_valid_i, wr_addr_i, wr_granules_i,
        input  lr_ready_o, sc_ready_o, sc_rsp_valid_o, sc_rsp_id_o, sc_rsp_ok_o, resv_count_o
    );

    modport slave (
        input  lr_valid_i, lr_id_i, lr_addr_i, sc_valid_i, sc_id_i, sc_addr_i,
               sc_rsp_ready_i, wr_valid_i, wr_addr_i, wr_granules_i,
        output lr_ready_o, sc_ready_o, sc_rsp_valid_o, sc_rsp_id_o, sc_rsp_ok_o, resv_count_o
    );
endinterface

// File: rtl/axi_riscv_resv_table_entry.sv
// axi_riscv_resv_entry: one reservation slot with owner ID, granule, lifetime
// counter and write-range snoop.
module axi_riscv_resv_entry
    import axi_riscv_resv_pkg::*;
#(
    parameter int ID_WIDTH       = 4,
    parameter int GRANULE_WIDTH  = 61,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         i_clr,
    input  logic                         i_load,
    input  logic [ID_WIDTH-1:0]          i_id,
    input  logic [GRANULE_WIDTH-1:0]     i_granule,
    input  logic                         i_wr_valid,
    input  logic [GRANULE_WIDTH-1:0]     i_wr_start,
    input  logic [GRANULE_CNT_WIDTH-1:0] i_wr_granules,
    output logic                         o_valid,
    output logic [ID_WIDTH-1:0]          o_id,
    output logic [GRANULE_WIDTH-1:0]     o_granule,
    output logic                         o_expire,
    output logic                         o_wr_hit
);
    localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic                     r_valid;
    logic [ID_WIDTH-1:0]      r_id;
    logic [GRANULE_WIDTH-1:0] r_granule;
    logic [CW-1:0]            r_cnt;

    // Expiry is taken on the last live cycle, so the entry is still visible to an SC then.
    assign o_expire  = (TIMEOUT_CYCLES > 0) && r_valid && (r_cnt == CW'(1));
    assign o_wr_hit  = i_wr_valid && r_valid &&
                       granule_in_range(64'(r_granule), 64'(i_wr_start), i_wr_granules);
    assign o_valid   = r_valid;
    assign o_id      = r_id;
    assign o_granule = r_granule;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid   <= 1'b0;
            r_id      <= '0;
            r_granule <= '0;
            r_cnt     <= '0;
        end else if (i_load) begin
            r_valid   <= 1'b1;
            r_id      <= i_id;
            r_granule <= i_granule;
            r_cnt     <= CW'(TIMEOUT_CYCLES);
        end else if (i_clr || o_expire) begin
            r_valid   <= 1'b0;
        end else if (r_valid && TIMEOUT_CYCLES > 0) begin
            r_cnt     <= r_cnt - CW'(1);
        end
    end
endmodule

// File: rtl/axi_riscv_resv_table.sv
// axi_riscv_resv_table: multi-entry LR/SC reservation table; each cycle applies
// write invalidation, then SC evaluation, then LR installation.
module axi_riscv_resv_table
    import axi_riscv_resv_pkg::*;
#(
    parameter int ID_WIDTH       = 4,
    parameter int ADDR_WIDTH     = 64,
    parameter int ADDR_LSB       = 3,
    parameter int NUM_ENTRIES    = 4,
    parameter int TIMEOUT_CYCLES = 0
) (
    input logic                   clk_i,
    input logic                   rst_ni,
    axi_riscv_resv_table_if.slave bus
);
    localparam int GW = ADDR_WIDTH - ADDR_LSB;
    localparam int IW = NUM_ENTRIES > 1 ? $clog2(NUM_ENTRIES) : 1;
    localparam int CW = $clog2(NUM_ENTRIES + 1);

    typedef struct packed {
        logic                valid;
        logic [ID_WIDTH-1:0] id;
        logic [GW-1:0]       granule;
    } entry_t;

    entry_t [NUM_ENTRIES-1:0] w_ent;
    logic [NUM_ENTRIES-1:0]   w_valid, w_expire, w_wr_hit, w_v1, w_sc_id_hit, w_sc_hit;
    logic [NUM_ENTRIES-1:0]   w_sc_clr, w_v2, w_own, w_load, w_v_next;
    logic [ID_WIDTH-1:0]      w_id [NUM_ENTRIES];
    logic [GW-1:0]            w_gran [NUM_ENTRIES];
    logic [GW-1:0]            w_sc_g, w_lr_g, w_wr_s;
    logic                     w_sc_ready, w_sc_fire, w_lr_fire, w_sc_ok;
    logic                     w_has_own, w_has_free, w_evict;
    logic [IW-1:0]            w_own_idx, w_free_idx, w_idx, r_victim;
    logic [CW-1:0]            w_pop, r_count;
    logic                     r_alive, r_rsp_valid, r_rsp_ok;
    logic [ID_WIDTH-1:0]      r_rsp_id;

    assign w_sc_g     = bus.sc_addr_i[ADDR_WIDTH-1:ADDR_LSB];
    assign w_lr_g     = bus.lr_addr_i[ADDR_WIDTH-1:ADDR_LSB];
    assign w_wr_s     = bus.wr_addr_i[ADDR_WIDTH-1:ADDR_LSB];
    assign w_sc_ready = r_alive && (!r_rsp_valid || bus.sc_rsp_ready_i);
    assign w_sc_fire  = bus.sc_valid_i && w_sc_ready;
    assign w_lr_fire  = bus.lr_valid_i && r_alive;
    assign w_sc_ok    = w_sc_fire && |w_sc_hit;

    for (genvar e = 0; e < NUM_ENTRIES; e++) begin : g_slot
        axi_riscv_resv_entry #(
            .ID_WIDTH(ID_WIDTH), .GRANULE_WIDTH(GW), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
        ) u_entry (
            .clk_i, .rst_ni,
            .i_clr(w_wr_hit[e] || w_sc_clr[e]), .i_load(w_load[e]),
            .i_id(bus.lr_id_i), .i_granule(w_lr_g),
            .i_wr_valid(bus.wr_valid_i), .i_wr_start(w_wr_s), .i_wr_granules(bus.wr_granules_i),
            .o_valid(w_valid[e]), .o_id(w_id[e]), .o_granule(w_gran[e]),
            .o_expire(w_expire[e]), .o_wr_hit(w_wr_hit[e])
        );
        assign w_ent[e]       = {w_valid[e], w_id[e], w_gran[e]};
        assign w_v1[e]        = w_ent[e].valid && !w_wr_hit[e];
        assign w_sc_id_hit[e] = w_v1[e] && (w_ent[e].id == bus.sc_id_i);
        assign w_sc_hit[e]    = w_sc_id_hit[e] && (w_ent[e].granule == w_sc_g);
        // A successful SC also kills every other reservation on the same granule.
        assign w_sc_clr[e]    = w_sc_fire && (w_sc_id_hit[e] ||
                                (w_sc_ok && w_v1[e] && w_ent[e].granule == w_sc_g));
        assign w_v2[e]        = w_v1[e] && !w_sc_clr[e];
        assign w_own[e]       = w_v2[e] && (w_ent[e].id == bus.lr_id_i);
        assign w_load[e]      = w_lr_fire && (w_idx == IW'(e));
        assign w_v_next[e]    = w_load[e] || (w_v2[e] && !w_expire[e]);
    end

    always_comb begin
        w_own_idx  = '0;
        w_free_idx = '0;
        w_has_own  = 1'b0;
        w_has_free = 1'b0;
        w_pop      = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (w_own[i]) begin
                w_has_own = 1'b1;
                w_own_idx = IW'(i);
            end
            if (!w_v2[i]) begin
                w_has_free = 1'b1;
                w_free_idx = IW'(i);
            end
            w_pop = w_pop + CW'(w_v_next[i]);
        end
    end

    assign w_idx   = w_has_own ? w_own_idx : (w_has_free ? w_free_idx : r_victim);
    assign w_evict = w_lr_fire && !w_has_own && !w_has_free;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_alive     <= 1'b0;
            r_victim    <= '0;
            r_count     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_ok    <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            r_count <= w_pop;
            if (w_evict)
                r_victim <= (r_victim == IW'(NUM_ENTRIES - 1)) ? '0 : r_victim + IW'(1);
            if (w_sc_fire) begin
                r_rsp_valid <= 1'b1;
                r_rsp_id    <= bus.sc_id_i;
                r_rsp_ok    <= w_sc_ok;
            end else if (bus.sc_rsp_ready_i) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign bus.lr_ready_o     = r_alive;
    assign bus.sc_ready_o     = w_sc_ready;
    assign bus.sc_rsp_valid_o = r_rsp_valid;
    assign bus.sc_rsp_id_o    = r_rsp_id;
    assign bus.sc_rsp_ok_o    = r_rsp_ok;
    assign bus.resv_count_o   = r_count;
endmodule

// File: tb/tb_axi_riscv_resv_table.sv
// tb_axi_riscv_resv_table: directed plan plus random traffic against an
// array-based reservation model; SC responses are scoreboarded.
module tb_axi_riscv_resv_table;
    localparam int N = 4;
    localparam int T = 5;

    typedef struct packed {
        logic [3:0] id;
        logic       ok;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    axi_riscv_resv_table_if #(.ID_WIDTH(4), .ADDR_WIDTH(64), .NUM_ENTRIES(N)) bus ();

    axi_riscv_resv_table #(
        .ID_WIDTH(4), .ADDR_WIDTH(64), .ADDR_LSB(3), .NUM_ENTRIES(N), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .bus(bus.slave)
    );

    bit              m_v [N];
    int              m_id [N];
    longint unsigned m_g [N];
    int              m_life [N];
    int              m_victim;
    bit              m_alive, m_rsp_valid;
    rsp_t            q[$];
    int              exp_count;
    bit              exp_rsp_valid;
    int              n_vec, n_err;

    logic [63:0] pool [6] = '{64'h100, 64'h108, 64'h118, 64'h200,
                              64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF0};

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint unsigned gr(input logic [63:0] a);
        return a >> 3;
    endfunction

    function automatic int mcount();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_v[i]);
        return c;
    endfunction

    task automatic drive(input bit lv, input int lid, input logic [63:0] la, input bit sv,
                         input int sid, input logic [63:0] sa, input bit wv,
                         input logic [63:0] wa, input int wn, input bit rr);
        bus.lr_valid_i = lv; bus.lr_id_i = 4'(lid); bus.lr_addr_i = la;
        bus.sc_valid_i = sv; bus.sc_id_i = 4'(sid); bus.sc_addr_i = sa;
        bus.wr_valid_i = wv; bus.wr_addr_i = wa; bus.wr_granules_i = 8'(wn);
        bus.sc_rsp_ready_i = rr;
    endtask

    // One clock of stimulus; the model then advances to the post-edge table.
    task automatic cyc(input bit lv, input int lid, input logic [63:0] la, input bit sv,
                       input int sid, input logic [63:0] sa, input bit wv,
                       input logic [63:0] wa, input int wn, input bit rr);
        bit sc_rdy, hit;
        int k;
        @(posedge clk); #2;
        drive(lv, lid, la, sv, sid, sa, wv, wa, wn, rr);
        sc_rdy = m_alive && (!m_rsp_valid || rr);
        exp_count = mcount();
        exp_rsp_valid = m_rsp_valid;
        #1;
        chk("lr_ready", bus.lr_ready_o, m_alive);
        chk("sc_ready", bus.sc_ready_o, sc_rdy);
        if (wv)
            for (int i = 0; i < N; i++)
                if (m_v[i] && m_g[i] >= gr(wa) && m_g[i] <= gr(wa) + 64'(wn)) m_v[i] = 0;
        if (sv && sc_rdy) begin
            hit = 0;
            for (int i = 0; i < N; i++)
                if (m_v[i] && m_id[i] == sid && m_g[i] == gr(sa)) hit = 1;
            for (int i = 0; i < N; i++)
                if (m_v[i] && (m_id[i] == sid || (hit && m_g[i] == gr(sa)))) m_v[i] = 0;
            q.push_back('{id: 4'(sid), ok: hit});
            m_rsp_valid = 1;
        end else if (rr) m_rsp_valid = 0;
        k = -1;
        if (lv && m_alive) begin
            for (int i = 0; i < N; i++) if (m_v[i] && m_id[i] == lid) k = i;
            if (k < 0) for (int i = N - 1; i >= 0; i--) if (!m_v[i]) k = i;
            if (k < 0) begin
                k = m_victim;
                m_victim = (m_victim + 1) % N;
            end
            m_v[k] = 1; m_id[k] = lid; m_g[k] = gr(la); m_life[k] = T;
        end
        for (int i = 0; i < N; i++)
            if (i != k && m_v[i]) begin
                m_life[i]--;
                if (m_life[i] == 0) m_v[i] = 0;
            end
        m_alive = 1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic lr(input int id, input logic [63:0] a);
        cyc(1, id, a, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic sc(input int id, input logic [63:0] a);
        cyc(0, 0, 0, 1, id, a, 0, 0, 0, 1);
    endtask

    // Reset lands mid-cycle; outputs must drop before the next edge.
    task automatic do_reset();
        @(posedge clk); #2;
        rst_ni = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < N; i++) m_v[i] = 0;
        m_victim = 0; m_rsp_valid = 0; m_alive = 0;
        q.delete();
        exp_count = 0; exp_rsp_valid = 0;
        #1;
        chk("rst_rsp_valid", bus.sc_rsp_valid_o, 0);
        chk("rst_count", bus.resv_count_o, 0);
        chk("rst_rsp_ok", bus.sc_rsp_ok_o, 0);
        chk("rst_rsp_id", bus.sc_rsp_id_o, 0);
        chk("rst_lr_ready", bus.lr_ready_o, 0);
        chk("rst_sc_ready", bus.sc_ready_o, 0);
        repeat (2) @(posedge clk);
        #2 rst_ni = 1;
        #1 chk("post_rst_lr_ready", bus.lr_ready_o, 0);
        m_alive = 1;
    endtask

    initial forever begin
        @(negedge clk);
        if (rst_ni) begin
            chk("resv_count", bus.resv_count_o, exp_count);
            chk("rsp_valid", bus.sc_rsp_valid_o, exp_rsp_valid);
            if (bus.sc_rsp_valid_o) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL rsp_unexpected: got id %0h with empty scoreboard", bus.sc_rsp_id_o);
                end else begin
                    chk("rsp_id", bus.sc_rsp_id_o, q[0].id);
                    chk("rsp_ok", bus.sc_rsp_ok_o, q[0].ok);
                    if (bus.sc_rsp_ready_i) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        do_reset();
        lr(2, 64'h100); sc(2, 64'h100); sc(2, 64'h100); idle(2);
        lr(1, 64'h118); cyc(0, 0, 0, 0, 0, 0, 1, 64'h100, 3, 1); sc(1, 64'h118);
        lr(1, 64'h118); cyc(0, 0, 0, 0, 0, 0, 1, 64'h100, 2, 1); sc(1, 64'h118); idle(2);
        do_reset();
        for (int i = 0; i < 5; i++) lr(i, 64'h400 + 64'(i * 8));
        sc(0, 64'h400); sc(4, 64'h420); idle(6);
        lr(3, 64'h200);
        cyc(1, 3, 64'h200, 1, 3, 64'h200, 1, 64'h200, 0, 1);
        sc(3, 64'h200); idle(6);
        lr(5, 64'h300); idle(4); sc(5, 64'h300);
        lr(5, 64'h300); idle(5); sc(5, 64'h300); idle(2);
        lr(6, 64'hFFFF_FFFF_FFFF_FFF8);
        cyc(0, 0, 0, 0, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFF0, 255, 1);
        sc(6, 64'hFFFF_FFFF_FFFF_FFFC); idle(2);
        lr(2, 64'h100);
        cyc(0, 0, 0, 1, 2, 64'h100, 0, 0, 0, 0);
        repeat (10) cyc(0, 0, 0, 1, 2, 64'h100, 0, 0, 0, 0);
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            cyc($urandom_range(0, 1), $urandom_range(0, 5), pool[$urandom_range(0, 5)],
                $urandom_range(0, 1), $urandom_range(0, 5),
                pool[$urandom_range(0, 5)] | 64'($urandom_range(0, 7)),
                $urandom_range(0, 3) == 0, pool[$urandom_range(0, 5)],
                $urandom_range(0, 9) == 0 ? 255 : $urandom_range(0, 3),
                $urandom_range(0, 3) != 0);
        end
        idle(5);
        chk("scoreboard_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
